// File: rtl/ram_access_unit_if.sv
// Request/response bundle between memory_control (master) and ram_access_unit (slave).
interface ram_access_unit_if;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );
endinterface

// File: rtl/ram_access_unit.sv
// Word-addressed RAM behind a FREE/BUSY/ACCESS/ERROR handshake with a programmable
// number of BUSY cycles before each access.
module ram_access_unit #(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    ram_access_unit_if.slave ram
);
    localparam int         IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // With zero latency an accepted request skips the BUSY phase entirely.
    localparam state_t ACCEPT_ST = (LAT == 0) ? ST_DONE : ST_WAIT;

    state_t          state_r;
    state_t          state_next_s;
    logic [3:0]      cnt_r;
    logic [3:0]      cnt_next_s;
    logic [31:0]     addr_r;
    logic [31:0]     addr_next_s;
    logic            wr_r;
    logic            wr_next_s;
    logic [1:0]      ramstate_r;
    logic [31:0]     rd_data_s;
    logic            req_any_s;
    logic            legal_s;
    logic            changed_s;
    logic [IDXW-1:0] idx_s;
    logic [31:0]     mem_r [DEPTH];

    function automatic logic [1:0] decode_state(input state_t st);
        logic [1:0] rs;
        case (st)
            ST_IDLE: rs = RS_FREE;
            ST_WAIT: rs = RS_BUSY;
            ST_DONE: rs = RS_ACCESS;
            ST_ERR:  rs = RS_ERROR;
            default: rs = RS_FREE;
        endcase
        return rs;
    endfunction

    assign req_any_s = ram.ramREN | ram.ramWEN;
    assign legal_s   = (ram.ramREN ^ ram.ramWEN)
                     && (ram.ramaddr[1:0] == 2'b00)
                     && ({2'b00, ram.ramaddr[31:2]} < 32'(DEPTH));
    // A held request whose address or direction moved is treated as a fresh one.
    assign changed_s = (ram.ramaddr != addr_r)
                     || (ram.ramWEN != wr_r)
                     || (ram.ramREN == wr_r);
    assign idx_s     = addr_r[IDXW+1:2];

    // Next-state, counter and latched-request computation.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        addr_next_s  = addr_r;
        wr_next_s    = wr_r;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    if (legal_s) begin
                        addr_next_s  = ram.ramaddr;
                        wr_next_s    = ram.ramWEN;
                        cnt_next_s   = CNT_LOAD;
                        state_next_s = ACCEPT_ST;
                    end else begin
                        state_next_s = ST_ERR;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req_any_s) begin
                    state_next_s = ST_IDLE;
                end else if (changed_s) begin
                    if (legal_s) begin
                        addr_next_s  = ram.ramaddr;
                        wr_next_s    = ram.ramWEN;
                        cnt_next_s   = CNT_LOAD;
                        state_next_s = ACCEPT_ST;
                    end else begin
                        state_next_s = ST_ERR;
                    end
                end else if (cnt_r == 4'd0) begin
                    state_next_s = ST_DONE;
                end else begin
                    cnt_next_s   = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            ST_ERR: begin
                if (!req_any_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ERR;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM, latched request and registered ramstate; ramstate tracks the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            addr_r     <= 32'd0;
            wr_r       <= 1'b0;
            ramstate_r <= RS_FREE;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            addr_r     <= addr_next_s;
            wr_r       <= wr_next_s;
            ramstate_r <= decode_state(state_next_s);
        end
    end

    // Storage write: commits at the edge closing the ACCESS cycle unless reset aborts it.
    always_ff @(posedge CLK) begin
        if (!RST && (state_r == ST_DONE) && wr_r) begin
            mem_r[idx_s] <= ram.ramstore;
        end
    end

    // Read data is presented only during a read ACCESS cycle.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if ((state_r == ST_DONE) && !wr_r) begin
            rd_data_s = mem_r[idx_s];
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    assign ram.ramload  = rd_data_s;
    assign ram.ramstate = ramstate_r;
endmodule

// File: tb/tb_ram_access_unit.sv
// Randomized bench for ram_access_unit: a cycle-level behavioural model predicts
// ramstate/ramload every cycle, plus directed scenarios with fixed expectations.
module tb_ram_access_unit;
    localparam int TB_LAT   = 2;
    localparam int TB_DEPTH = 1024;
    localparam logic [1:0] E0 [8] = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_on   = 1'b0;

    ram_access_unit_if ram ();
    ram_access_unit_if ram0 ();

    ram_access_unit #(.LAT(TB_LAT), .DEPTH(TB_DEPTH)) dut (.CLK(clk), .RST(rst), .ram(ram));
    ram_access_unit #(.LAT(0), .DEPTH(TB_DEPTH)) dut0 (.CLK(clk), .RST(rst), .ram(ram0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // model: phase 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
    int             m_phase = 0;
    int             m_busy  = 0;
    logic [31:0]    m_addr  = 32'd0;
    logic           m_wr    = 1'b0;
    logic [31:0]    mm [int];

    logic           rn, wn;
    logic [31:0]    a;
    bit             act;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal_f(input logic r_en, input logic w_en, input logic [31:0] ad);
        return (r_en ^ w_en) && (ad[1:0] == 2'b00) && ((ad >> 2) < 32'(TB_DEPTH));
    endfunction

    task automatic model_step(input logic r, input logic r_en, input logic w_en,
                              input logic [31:0] ad, input logic [31:0] d);
        if (r) begin
            m_phase = 0;
            m_busy  = 0;
        end else begin
            case (m_phase)
                0: if (r_en || w_en) begin
                    if (legal_f(r_en, w_en, ad)) begin
                        m_addr = ad; m_wr = w_en; m_busy = 1;
                        m_phase = (TB_LAT == 0) ? 2 : 1;
                    end else m_phase = 3;
                end
                1: if (!(r_en || w_en)) m_phase = 0;
                   else if (ad != m_addr || w_en != m_wr || r_en == m_wr) begin
                       if (legal_f(r_en, w_en, ad)) begin
                           m_addr = ad; m_wr = w_en; m_busy = 1; m_phase = 1;
                       end else m_phase = 3;
                   end
                   else if (m_busy >= TB_LAT) m_phase = 2;
                   else m_busy++;
                2: begin
                    if (m_wr) mm[int'(m_addr >> 2)] = d;
                    m_phase = 0;
                end
                default: if (!(r_en || w_en)) m_phase = 0;
            endcase
        end
    endtask

    // One clock cycle, entered and left at a falling edge: compare, drive, advance the model.
    task automatic cyc(input logic r, input logic r_en, input logic w_en, input logic [31:0] ad,
                       input logic [31:0] d, input int exp_st, input string tag);
        if (chk_on) begin
            check_eq("state", 32'(ram.ramstate), 32'(m_phase));
            if (m_phase == 2 && !m_wr) begin
                if (mm.exists(int'(m_addr >> 2)))
                    check_eq("load", ram.ramload, mm[int'(m_addr >> 2)]);
            end else begin
                check_eq("load_idle", ram.ramload, 32'h0);
            end
        end
        if (exp_st >= 0) check_eq(tag, 32'(ram.ramstate), 32'(exp_st));
        rst = r;
        ram.ramREN = r_en; ram.ramWEN = w_en; ram.ramaddr = ad; ram.ramstore = d;
        model_step(r, r_en, w_en, ad, d);
        @(negedge clk);
    endtask

    task automatic xfer(input logic w_en, input logic [31:0] ad, input logic [31:0] d);
        int n = 0;
        while (ram.ramstate != 2'd2 && n < 40) begin
            cyc(1'b0, !w_en, w_en, ad, d, -1, "");
            n++;
        end
        check_eq("xfer_timeout", 32'(n >= 40), 32'd0);
        cyc(1'b0, !w_en, w_en, ad, d, -1, "");
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, -1, "");
    endtask

    task automatic new_req();
        int k = $urandom_range(0, 99);
        if (k < 8) begin rn = 1'b1; wn = 1'b1; end
        else begin wn = $urandom_range(0, 1); rn = !wn; end
        k = $urandom_range(0, 99);
        if (k < 85)      a = 32'($urandom_range(0, 31)) << 2;
        else if (k < 92) a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
        else             a = 32'h0000_1000 + (32'($urandom_range(0, 7)) << 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prior;
        rst = 1'b1;
        ram.ramREN = 1'b0; ram.ramWEN = 1'b0; ram.ramaddr = 32'd0; ram.ramstore = 32'd0;
        ram0.ramREN = 1'b0; ram0.ramWEN = 1'b0; ram0.ramaddr = 32'd0; ram0.ramstore = 32'd0;
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, -1, "");
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, -1, "");
        check_eq("rst_state", 32'(ram.ramstate), 32'd0);
        check_eq("rst_load", ram.ramload, 32'd0);
        chk_on = 1'b1;

        // known contents for words 0..31; bit 31 set so no word can equal 0x55
        for (int i = 0; i < 32; i++) xfer(1'b1, 32'(i) << 2, 32'h8000_0000 | $urandom());

        // write 0xDEADBEEF held, then read it back
        cyc(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, "wr_c0");
        cyc(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1, "wr_c1");
        cyc(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1, "wr_c2");
        cyc(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2, "wr_c3");
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, "wr_c4");
        cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 0, "rd_c0");
        cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1, "rd_c1");
        cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1, "rd_c2");
        check_eq("rd_deadbeef", ram.ramload, 32'hDEADBEEF);
        cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2, "rd_c3");
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, "rd_c4");

        // illegal requests
        cyc(1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 0, "both_c0");
        cyc(1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 3, "both_c1");
        cyc(1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 3, "both_c2");
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3, "both_drop");
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, "both_free");
        cyc(1'b0, 1'b1, 1'b0, 32'h22, 32'h0, 0, "mis_c0");
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3, "mis_err");
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, "mis_free");
        cyc(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 0, "oor_c0");
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3, "oor_err");
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, "oor_free");

        // address change during BUSY restarts the latency
        cyc(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 0, "chg_c0");
        cyc(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 1, "chg_c1");
        cyc(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 1, "chg_c2");
        cyc(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 1, "chg_c3");
        check_eq("chg_load", ram.ramload, mm[17]);
        cyc(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 2, "chg_c4");
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, "chg_c5");

        // reset during BUSY aborts the write
        prior = mm[2];
        cyc(1'b0, 1'b0, 1'b1, 32'h8, 32'h55, 0, "abort_c0");
        cyc(1'b1, 1'b0, 1'b1, 32'h8, 32'h55, 1, "abort_c1");
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, "abort_c2");
        cyc(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 0, "abort_r0");
        cyc(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1, "abort_r1");
        cyc(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1, "abort_r2");
        check_eq("abort_load", ram.ramload, prior);
        cyc(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 2, "abort_r3");
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, "abort_r4");

        // random traffic against the model
        act = 1'b0; rn = 1'b0; wn = 1'b0; a = 32'd0;
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 99) < 2) begin
                act = 1'b0;
                cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, -1, "");
                continue;
            end
            if (!act) begin
                if ($urandom_range(0, 99) < 40) begin new_req(); act = 1'b1; end
            end else if (ram.ramstate == 2'd2) begin
                if ($urandom_range(0, 9) < 8) act = 1'b0;
            end else if (ram.ramstate == 2'd3) begin
                if ($urandom_range(0, 9) < 3) act = 1'b0;
            end else begin
                int r = $urandom_range(0, 99);
                if (r < 5) new_req();
                else if (r < 8) act = 1'b0;
            end
            cyc(1'b0, act & rn, act & wn, a, $urandom(), -1, "");
        end
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, -1, "");
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, -1, "");

        // zero-latency instance: write word 0, then read held (ACCESS/FREE alternating)
        for (int k = 0; k < 8; k++) begin
            check_eq("lat0_state", 32'(ram0.ramstate), 32'(E0[k]));
            if (k == 4 || k == 6) check_eq("lat0_load", ram0.ramload, 32'hA5A5_5A5A);
            else check_eq("lat0_load_idle", ram0.ramload, 32'h0);
            ram0.ramWEN   = (k < 2);
            ram0.ramREN   = (k >= 3);
            ram0.ramaddr  = 32'h0;
            ram0.ramstore = 32'hA5A5_5A5A;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
